fba_accumulator: RTL and testbench

//   Streaming approximate accumulator for the CNN datapath: sums N_TERMS unsigned 16-bit

---
 rtl/fba_accumulator_pkg.sv | 17 +
 rtl/fba_accumulator_adder.sv | 41 ++++
 rtl/fba_accumulator.sv | 102 ++++++++++
 tb/tb_fba_accumulator.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fba_accumulator_pkg.sv
// Shared definitions for the fixed-bounding-adder accumulator slice.
//   DATA_W   : datapath width of products and partial sums
//   APPROX_W : width of the approximated low part of the adder
//   SAT_VAL  : value the accumulator pins to once a window saturates
//   state_e  : accumulator control states
package fba_accumulator_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned APPROX_W = 8;
  localparam logic [DATA_W-1:0] SAT_VAL = 16'hFFFF;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage : fba_accumulator_pkg

// File: rtl/fba_accumulator_adder.sv
// fba_adder: 16-bit fixed-bounding approximate adder.
//   A, B : unsigned operands
//   Y    : approximate sum
//   cout : carry out of the exact upper byte
// The upper byte is an exact add of the operands' upper bytes. The lower byte
// never propagates a carry: above the highest bit position where both operands
// are 1 it is a plain OR, and that position and everything below it read as 1.
module fba_adder
  import fba_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Y,
  output logic              cout
);

  localparam int unsigned HI_W = DATA_W - APPROX_W;

  logic [HI_W:0]       hi_sum;
  logic [APPROX_W-1:0] gen;
  logic [APPROX_W-1:0] fill;
  logic [APPROX_W-1:0] lo_sum;

  always_comb begin
    hi_sum = {1'b0, A[DATA_W-1:APPROX_W]} + {1'b0, B[DATA_W-1:APPROX_W]};
    gen    = A[APPROX_W-1:0] & B[APPROX_W-1:0];

    // Prefix-OR from the MSB down: fill[j] is set when any generate bit sits
    // at or above j, i.e. every position at or below the highest generate.
    fill               = '0;
    fill[APPROX_W-1]   = gen[APPROX_W-1];
    for (int unsigned k = 1; k < APPROX_W; k++) begin
      fill[APPROX_W-1-k] = fill[APPROX_W-k] | gen[APPROX_W-1-k];
    end

    lo_sum = A[APPROX_W-1:0] | B[APPROX_W-1:0] | fill;
    Y      = {hi_sum[HI_W-1:0], lo_sum};
    cout   = hi_sum[HI_W];
  end

endmodule : fba_adder

// File: rtl/fba_accumulator.sv
// fba_accumulator: streaming approximate accumulator. Sums N_TERMS unsigned
// 16-bit products through fba_adder and emits one saturated partial sum per
// window over a valid/ready handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : product input handshake, in_data is the term
//   out_valid/out_ready  : result handshake; out_sum/out_sat held until taken
//   out_sum              : approximate window sum, saturated to 16'hFFFF
//   out_sat              : saturation occurred somewhere in the window
module fba_accumulator
  import fba_accumulator_pkg::*;
#(
  parameter int N_TERMS = 9,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_sat
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              osat_q, osat_d;

  logic [DATA_W-1:0] add_y;
  logic              add_cout;

  fba_adder u_adder (
    .A    (acc_q),
    .B    (in_data),
    .Y    (add_y),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sum_q   <= sum_d;
      osat_q  <= osat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    sum_d   = sum_q;
    osat_d  = osat_q;

    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          // Saturation is sticky for the rest of the window.
          sat_d = sat_q | add_cout;
          acc_d = sat_d ? SAT_VAL : add_y;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_HOLD;
            sum_d   = acc_d;
            osat_d  = sat_d;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = sum_q;
  assign out_sat   = osat_q;

endmodule : fba_accumulator

// File: tb/tb_fba_accumulator.sv
module tb_fba_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // a: N_TERMS=3, b: N_TERMS=9, c: N_TERMS=1
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
  logic [15:0] a_in_data, a_out_sum;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat;
  logic [15:0] b_in_data, b_out_sum;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_sat;
  logic [15:0] c_in_data, c_out_sum;

  fba_accumulator #(.N_TERMS(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_sat(a_out_sat)
  );

  fba_accumulator #(.N_TERMS(9), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_sat(b_out_sat)
  );

  fba_accumulator #(.N_TERMS(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_sat(c_out_sat)
  );

  // Reference adder: scan for the highest common bit, then fill below it.
  function automatic logic [16:0] fba_ref(input logic [15:0] a, input logic [15:0] b);
    logic [8:0] hi;
    logic [7:0] lo;
    int top;
    hi  = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    lo  = a[7:0] | b[7:0];
    top = -1;
    for (int i = 7; i >= 0; i--)
      if (top < 0 && a[i] && b[i]) top = i;
    for (int i = 0; i <= top; i++) lo[i] = 1'b1;
    return {hi, lo};
  endfunction

  // Each send is entered at a negedge and returns at the negedge after the
  // handshake edge, with in_valid still asserted.
  task automatic a_send(input logic [15:0] d);
    int n = 0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL a_send_timeout got in_ready=%b exp=1", a_in_ready);
    end
    @(negedge clk);
  endtask

  task automatic b_send(input logic [15:0] d);
    int n = 0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL b_send_timeout got in_ready=%b exp=1", b_in_ready);
    end
    @(negedge clk);
  endtask

  task automatic a_expect_out(input string nm, input logic [15:0] s, input logic sat);
    checks++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_sum !== s || a_out_sat !== sat) begin
      errors++;
      $display("FAIL %s got v=%b rdy=%b sum=%h sat=%b exp v=1 rdy=0 sum=%h sat=%b",
               nm, a_out_valid, a_in_ready, a_out_sum, a_out_sat, s, sat);
    end
  endtask

  task automatic test_reset;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_sum !== 16'h0 || a_out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b rdy=%b sum=%h sat=%b exp v=0 rdy=1 sum=0000 sat=0",
               a_out_valid, a_in_ready, a_out_sum, a_out_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midwindow;
    for (int i = 0; i < 9; i++) b_send(16'h0100);
    b_in_valid = 0;
    checks++;
    if (b_out_valid !== 1'b1 || b_out_sum !== 16'h0900 || b_out_sat !== 1'b0) begin
      errors++;
      $display("FAIL n9_window got v=%b sum=%h sat=%b exp v=1 sum=0900 sat=0",
               b_out_valid, b_out_sum, b_out_sat);
    end
    b_out_ready = 1;
    @(negedge clk);
    b_out_ready = 0;
    for (int i = 0; i < 4; i++) b_send(16'h0001);
    b_in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_sum !== 16'h0 || b_out_sat !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b rdy=%b sum=%h sat=%b exp v=0 rdy=1 sum=0000 sat=0",
               b_out_valid, b_in_ready, b_out_sum, b_out_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) b_send(16'h0100);
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_count got v=%b exp v=0 after 8 terms", b_out_valid);
    end
    b_send(16'h0100);
    b_in_valid = 0;
    checks++;
    if (b_out_valid !== 1'b1 || b_out_sum !== 16'h0900) begin
      errors++;
      $display("FAIL post_reset_window got v=%b sum=%h exp v=1 sum=0900", b_out_valid, b_out_sum);
    end
    b_out_ready = 1;
    @(negedge clk);
    b_out_ready = 0;
  endtask

  task automatic test_single_term;
    logic [15:0] vals [2];
    vals[0] = 16'hABCD;
    vals[1] = 16'h1111;
    c_out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      c_in_valid = 1; c_in_data = vals[i];
      @(negedge clk);
      c_in_valid = 0;
      checks++;
      if (c_out_valid !== 1'b1 || c_out_sum !== vals[i] || c_out_sat !== 1'b0) begin
        errors++;
        $display("FAIL n1_term%0d got v=%b sum=%h sat=%b exp v=1 sum=%h sat=0",
                 i, c_out_valid, c_out_sum, c_out_sat, vals[i]);
      end
      @(negedge clk);
    end
    c_out_ready = 0;
  endtask

  task automatic test_exact_path;
    a_out_ready = 1;
    a_send(16'h0101);
    a_send(16'h0101);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid got v=%b exp v=0", a_out_valid);
    end
    a_send(16'h0101);
    a_in_valid = 0;
    a_expect_out("approx_0101x3", 16'h0301, 1'b0);
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_sum !== 16'h0301) begin
      errors++;
      $display("FAIL bubble_release got v=%b rdy=%b sum=%h exp v=0 rdy=1 sum=0301",
               a_out_valid, a_in_ready, a_out_sum);
    end
  endtask

  task automatic test_zero_load;
    a_out_ready = 1;
    a_send(16'h1234);
    a_send(16'h0000);
    a_send(16'h0000);
    a_in_valid = 0;
    a_expect_out("zero_load", 16'h1234, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_saturation;
    a_out_ready = 1;
    a_send(16'hF000);
    a_send(16'h2000);
    a_send(16'h0001);
    a_in_valid = 0;
    a_expect_out("saturate", 16'hFFFF, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) a_send(16'h0001);
    a_in_valid = 0;
    a_expect_out("sat_cleared", 16'h0001, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    a_out_ready = 0;
    a_send(16'h0102);
    a_send(16'h0203);
    a_send(16'h0001);
    a_in_data = 16'h0005;
    for (int i = 0; i < 5; i++) begin
      a_expect_out($sformatf("stall_%0d", i), 16'h0303, 1'b0);
      @(negedge clk);
    end
    a_out_ready = 1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got rdy=%b v=%b exp rdy=1 v=0", a_in_ready, a_out_valid);
    end
    @(negedge clk);
    a_send(16'h0000);
    a_send(16'h0000);
    a_in_valid = 0;
    a_expect_out("held_term_first", 16'h0005, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random;
    logic        m_hold = 0, m_sat = 0, m_osat;
    logic [15:0] m_acc = '0, m_sum;
    int          m_cnt = 0, wins = 0, cyc = 0, mism = 0;
    logic [16:0] r;
    logic        nsat;
    logic [15:0] nacc;
    m_sum  = a_out_sum;
    m_osat = a_out_sat;
    while (wins < 1000 && cyc < 40000) begin
      checks++;
      if (a_out_valid !== m_hold || a_in_ready !== !m_hold || a_out_sum !== m_sum || a_out_sat !== m_osat) begin
        errors++;
        mism++;
        if (mism <= 10)
          $display("FAIL random_cyc%0d got v=%b rdy=%b sum=%h sat=%b exp v=%b rdy=%b sum=%h sat=%b",
                   cyc, a_out_valid, a_in_ready, a_out_sum, a_out_sat, m_hold, !m_hold, m_sum, m_osat);
      end
      a_in_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a_in_data = 16'($urandom);
        1:       a_in_data = 16'($urandom) & 16'h0FFF;
        2:       a_in_data = 16'($urandom) & 16'h00FF;
        default: a_in_data = 16'($urandom) & 16'h03FF;
      endcase
      a_out_ready = ($urandom_range(0, 3) != 0);
      if (!m_hold) begin
        if (a_in_valid) begin
          r    = fba_ref(m_acc, a_in_data);
          nsat = r[16] | m_sat;
          nacc = nsat ? 16'hFFFF : r[15:0];
          m_acc = nacc;
          m_sat = nsat;
          m_cnt++;
          if (m_cnt == 3) begin
            m_hold = 1; m_sum = nacc; m_osat = nsat;
          end
        end
      end else if (a_out_ready) begin
        m_hold = 0; m_acc = '0; m_sat = 0; m_cnt = 0;
        wins++;
      end
      @(negedge clk);
      cyc++;
    end
    a_in_valid = 0;
    a_out_ready = 0;
    checks++;
    if (wins != 1000) begin
      errors++;
      $display("FAIL random_windows got %0d exp 1000", wins);
    end
  endtask

  initial begin
    test_reset;
    test_reset_midwindow;
    test_single_term;
    test_exact_path;
    test_zero_load;
    test_saturation;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fba_accumulator
